mult_div_unit: RTL and testbench



---
 rtl/mult_div_unit_if.sv | 32 +++
 rtl/mult_div_unit.sv | 99 +++++++++
 tb/tb_mult_div_unit.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: operand/control and HI/LO result bundle of the multiply/divide unit.
// DivZero exists only when MDU_DIVZERO_FLAG_EN is defined.
interface mult_div_unit_if #(parameter int WIDTH = 32);
    logic             Start;
    logic [1:0]       Op;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic             HiLoWrite;
    logic             HiLoSel;
    logic [WIDTH-1:0] HiLoWriteData;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;
`ifdef MDU_DIVZERO_FLAG_EN
    logic             DivZero;
`endif
    modport master (
        output Start, Op, SrcA, SrcB, HiLoWrite, HiLoSel, HiLoWriteData,
        input  Busy, Done, HI, LO
`ifdef MDU_DIVZERO_FLAG_EN
        , input DivZero
`endif
    );
    modport slave (
        input  Start, Op, SrcA, SrcB, HiLoWrite, HiLoSel, HiLoWriteData,
        output Busy, Done, HI, LO
`ifdef MDU_DIVZERO_FLAG_EN
        , output DivZero
`endif
    );
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MULT/MULTU/DIV/DIVU with HI/LO registers, WIDTH steps per op.
// Optional MDU_DIVZERO_FLAG_EN: divide-by-zero keeps HI/LO and pulses DivZero with Done.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input logic             clk,
    input logic             reset_n,
    mult_div_unit_if.slave  bus
);
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2;
    localparam int CW = $clog2(WIDTH);

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q;
    logic               div_q, neg_q, rneg_q, dz_q, done_q;
    logic [WIDTH-1:0]   m_q, hi_q, lo_q;
    logic [2*WIDTH-1:0] p_q, p_d, prod;
    logic [WIDTH:0]     sum, diff;
    logic [WIDTH-1:0]   a_mag, b_mag, quo, rem, res_hi, res_lo;
    logic               sgn, start, ge, wr_res;

    always_comb begin
        sgn     = !bus.Op[0];
        a_mag   = (sgn && bus.SrcA[WIDTH-1]) ? -bus.SrcA : bus.SrcA;
        b_mag   = (sgn && bus.SrcB[WIDTH-1]) ? -bus.SrcB : bus.SrcB;
        start   = state_q == IDLE && bus.Start;
        // p_q holds {acc, multiplier} for mult and {remainder, dividend/quotient} for div
        sum     = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, m_q} : '0);
        diff    = p_q[2*WIDTH-1:WIDTH-1] - {1'b0, m_q};
        ge      = !diff[WIDTH];
        p_d     = div_q ? {ge ? diff[WIDTH-1:0] : p_q[2*WIDTH-2:WIDTH-1], p_q[WIDTH-2:0], ge}
                        : {sum, p_q[WIDTH-1:1]};
        prod    = neg_q ? -p_q : p_q;
        quo     = neg_q ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
        rem     = rneg_q ? -p_q[2*WIDTH-1:WIDTH] : p_q[2*WIDTH-1:WIDTH];
        res_hi  = div_q ? rem : prod[2*WIDTH-1:WIDTH];
        res_lo  = !div_q ? prod[WIDTH-1:0] : dz_q ? '1 : quo;
`ifdef MDU_DIVZERO_FLAG_EN
        wr_res  = state_q == FIX && !dz_q;
`else
        wr_res  = state_q == FIX;
`endif
        state_d = state_q == IDLE ? (bus.Start ? RUN : IDLE)
                : state_q == RUN  ? (cnt_q == CW'(WIDTH - 1) ? FIX : RUN)
                : IDLE;
    end

`ifdef MDU_DIVZERO_FLAG_EN
    logic divz_q;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) divz_q <= 1'b0;
        else          divz_q <= state_q == FIX && dz_q;
    assign bus.DivZero = divz_q;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            div_q   <= 1'b0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            done_q  <= 1'b0;
            m_q     <= '0;
            p_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= state_q == FIX;
            if (start) begin
                cnt_q  <= '0;
                div_q  <= bus.Op[1];
                neg_q  <= sgn && (bus.SrcA[WIDTH-1] ^ bus.SrcB[WIDTH-1]);
                rneg_q <= sgn && bus.SrcA[WIDTH-1];
                dz_q   <= bus.Op[1] && bus.SrcB == '0;
                m_q    <= bus.Op[1] ? b_mag : a_mag;
                p_q    <= {{WIDTH{1'b0}}, bus.Op[1] ? a_mag : b_mag};
            end else if (state_q == RUN) begin
                cnt_q <= cnt_q + 1'b1;
                p_q   <= p_d;
            end
            // result write wins over MTHI/MTLO; the latter only lands while idle
            if (wr_res) begin
                hi_q <= res_hi;
                lo_q <= res_lo;
            end else if (state_q == IDLE && bus.HiLoWrite) begin
                if (bus.HiLoSel) hi_q <= bus.HiLoWriteData;
                else             lo_q <= bus.HiLoWriteData;
            end
        end
    end

    assign bus.Busy = state_q != IDLE;
    assign bus.Done = done_q;
    assign bus.HI   = hi_q;
    assign bus.LO   = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: randomized and directed checks of mult_div_unit against an arithmetic model.
// Build with MDU_DIVZERO_FLAG_EN defined to cover the DivZero variant.
module tb_mult_div_unit;
    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    mult_div_unit_if #(.WIDTH(32)) bus();
    mult_div_unit #(.WIDTH(32)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    int checks = 0;
    int errors = 0;
    logic [31:0] m_hi = '0, m_lo = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input bit poke);
        longint sa, sb, q, r;
        logic [63:0] p;
        logic [31:0] eh, el;
        bit dz;
        int n, nb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        dz = op[1] && b == 0;
        if (!op[1]) begin
            if (op[0]) p = {32'b0, a} * {32'b0, b};
            else       p = sa * sb;
            eh = p[63:32];
            el = p[31:0];
        end else if (dz) begin
`ifdef MDU_DIVZERO_FLAG_EN
            eh = m_hi;
            el = m_lo;
`else
            eh = a;
            el = '1;
`endif
        end else if (op[0]) begin
            eh = a % b;
            el = a / b;
        end else begin
            q = sa / sb;
            r = sa % sb;
            eh = r[31:0];
            el = q[31:0];
        end
        @(negedge clk);
        bus.Start = 1'b1; bus.Op = op; bus.SrcA = a; bus.SrcB = b;
        @(negedge clk);
        bus.SrcA = $urandom; bus.SrcB = $urandom;
        n = 1; nb = 0;
        while (bus.Done !== 1'b1 && n < 60) begin
            if (bus.Busy === 1'b1) nb++;
            bus.Start = poke && n == 5;
            bus.Op = 2'($urandom);
            bus.HiLoWrite = poke && n == 5;
            bus.HiLoSel = 1'b1;
            bus.HiLoWriteData = 32'hA5A5A5A5;
            @(negedge clk);
            n++;
        end
        bus.Start = 1'b0; bus.HiLoWrite = 1'b0;
        m_hi = eh; m_lo = el;
        chk("latency", 64'(n), 64'd34);
        chk("busy_cycles", 64'(nb), 64'd33);
        chk("busy_at_done", 64'(bus.Busy), 64'd0);
        chk("hi", 64'(bus.HI), 64'(eh));
        chk("lo", 64'(bus.LO), 64'(el));
`ifdef MDU_DIVZERO_FLAG_EN
        chk("divzero", 64'(bus.DivZero), 64'(dz));
`endif
        @(negedge clk);
        chk("done_single", 64'(bus.Done), 64'd0);
        chk("busy_after", 64'(bus.Busy), 64'd0);
`ifdef MDU_DIVZERO_FLAG_EN
        chk("divzero_clr", 64'(bus.DivZero), 64'd0);
`endif
    endtask

    task automatic hilo_write(input logic sel, input logic [31:0] d);
        @(negedge clk);
        bus.HiLoWrite = 1'b1; bus.HiLoSel = sel; bus.HiLoWriteData = d;
        @(negedge clk);
        bus.HiLoWrite = 1'b0;
        if (sel) m_hi = d;
        else     m_lo = d;
        chk("mt_hi", 64'(bus.HI), 64'(m_hi));
        chk("mt_lo", 64'(bus.LO), 64'(m_lo));
    endtask

    initial begin
        int seen;
        logic [1:0] op;
        logic [31:0] a, b;
        bus.Start = 1'b0; bus.Op = '0; bus.SrcA = '0; bus.SrcB = '0;
        bus.HiLoWrite = 1'b0; bus.HiLoSel = 1'b0; bus.HiLoWriteData = '0;
        #2 reset_n = 1'b0;
        @(negedge clk);
        chk("rst_busy", 64'(bus.Busy), 64'd0);
        chk("rst_done", 64'(bus.Done), 64'd0);
        chk("rst_hi", 64'(bus.HI), 64'd0);
        chk("rst_lo", 64'(bus.LO), 64'd0);
        reset_n = 1'b1;

        do_op(2'b00, 32'hFFFFFFFD, 32'd7, 0);
        chk("mult_hi_const", 64'(bus.HI), 64'h00000000FFFFFFFF);
        chk("mult_lo_const", 64'(bus.LO), 64'h00000000FFFFFFEB);
        do_op(2'b10, 32'hFFFFFFF9, 32'd2, 0);
        chk("div_lo_const", 64'(bus.LO), 64'h00000000FFFFFFFD);
        do_op(2'b11, 32'd100, 32'd7, 0);
        chk("divu_lo_const", 64'(bus.LO), 64'd14);
        do_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 0);
        chk("ovf_lo_const", 64'(bus.LO), 64'h0000000080000000);
        do_op(2'b11, 32'h1234, 32'd0, 0);
        do_op(2'b10, 32'hFFFF0000, 32'd0, 0);
        do_op(2'b01, $urandom, $urandom, 1);
        hilo_write(1'b1, 32'hA5A5A5A5);
        hilo_write(1'b0, $urandom);

        @(negedge clk);
        bus.Start = 1'b1; bus.Op = 2'b01; bus.SrcA = '1; bus.SrcB = '1;
        @(negedge clk);
        bus.Start = 1'b0;
        repeat (9) @(negedge clk);
        reset_n = 1'b0;
        #1;
        m_hi = '0; m_lo = '0;
        chk("mid_rst_busy", 64'(bus.Busy), 64'd0);
        chk("mid_rst_hi", 64'(bus.HI), 64'd0);
        chk("mid_rst_lo", 64'(bus.LO), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.Done === 1'b1) seen++;
        end
        chk("no_done_after_rst", 64'(seen), 64'd0);
        do_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        chk("multu_hi_const", 64'(bus.HI), 64'h00000000FFFFFFFE);

        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            a = $urandom_range(0, 5) == 0 ? 32'h80000000 : $urandom;
            case ($urandom_range(0, 7))
                0:       b = '0;
                1:       b = 32'($urandom_range(1, 20));
                2:       b = '1;
                default: b = $urandom;
            endcase
            do_op(op, a, b, i % 7 == 3);
        end

        repeat (10) @(negedge clk);
        chk("hold_hi", 64'(bus.HI), 64'(m_hi));
        chk("hold_lo", 64'(bus.LO), 64'(m_lo));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
